// File: rtl/seq_divider.sv
// Iterative restoring divider: signed/unsigned, K quotient bits per cycle,
// divide-by-zero flag, valid/ready on both the operand and result sides.
module seq_divider #(
  parameter int N = 64,
  parameter int M = 64,
  parameter int K = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_signed,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         div_by_zero,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  localparam int ITERS = N / K;
  localparam int CW    = $clog2(ITERS + 1);

  state_e         state_q, state_d;
  logic [N-1:0]   dvd_q, dvd_d;        // dividend magnitude, quotient shifts in at the LSB
  logic [M-1:0]   dvs_q, dvs_d;
  logic [M:0]     rem_q, rem_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           quo_neg_q, quo_neg_d;
  logic           rem_neg_q, rem_neg_d;
  logic [N-1:0]   quotient_q, quotient_d;
  logic [M-1:0]   remainder_q, remainder_d;
  logic           dbz_q, dbz_d;
  logic           out_valid_q, out_valid_d;

  logic           op_neg_dvd, op_neg_dvs;
  logic [N-1:0]   dvd_mag;
  logic [M-1:0]   dvs_mag;
  logic [N-1:0]   step_dvd;
  logic [M:0]     step_rem;

  // Full-width two's-complement negation: the most negative value maps to 2^(W-1).
  assign op_neg_dvd = in_signed & dividend[N-1];
  assign op_neg_dvs = in_signed & divisor[M-1];
  assign dvd_mag    = op_neg_dvd ? -dividend : dividend;
  assign dvs_mag    = op_neg_dvs ? -divisor  : divisor;

  // K chained restoring steps; the partial remainder stays below the divisor,
  // so its low M bits plus the incoming dividend bit form the M+1 bit trial.
  always_comb begin
    logic [M:0] trial;
    logic       qbit;
    step_rem = rem_q;
    step_dvd = dvd_q;
    trial    = '0;
    qbit     = 1'b0;
    for (int i = 0; i < K; i++) begin
      trial = {step_rem[M-1:0], step_dvd[N-1]};
      if (trial >= {1'b0, dvs_q}) begin
        step_rem = trial - {1'b0, dvs_q};
        qbit     = 1'b1;
      end else begin
        step_rem = trial;
        qbit     = 1'b0;
      end
      step_dvd = {step_dvd[N-2:0], qbit};
    end
  end

  always_comb begin
    // NOTE: every *_d gets its hold value first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    quo_neg_d   = quo_neg_q;
    rem_neg_d   = rem_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          quo_neg_d = op_neg_dvd ^ op_neg_dvs;
          rem_neg_d = op_neg_dvd;
          dvs_d     = dvs_mag;
          rem_d     = '0;
          cnt_d     = '0;
          if (divisor == '0) begin
            dvd_d   = dividend;   // raw operand: the zero-divisor result has no sign handling
            state_d = DONE;
          end else begin
            dvd_d   = dvd_mag;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        dvd_d = step_dvd;
        rem_d = step_rem;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITERS - 1)) state_d = FIX;
      end
      FIX: begin
        quotient_d  = quo_neg_q ? -dvd_q : dvd_q;
        remainder_d = rem_neg_q ? -rem_q[M-1:0] : rem_q[M-1:0];
        dbz_d       = 1'b0;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        // Entering DONE with out_valid low means a zero divisor: load that result now.
        if (!out_valid_q) begin
          quotient_d  = '1;
          remainder_d = dvd_q[M-1:0];
          dbz_d       = 1'b1;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      quo_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      quo_neg_q   <= quo_neg_d;
      rem_neg_q   <= rem_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench: an 8/8/1 instance for directed cases and a 64/32/4
// instance for a random sweep, both checked against an arithmetic model.
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // 8-bit instance (N=8, M=8, K=1)
  logic       a_in_valid, a_in_ready, a_in_signed, a_out_valid, a_out_ready, a_dbz, a_busy;
  logic [7:0] a_dividend, a_divisor, a_quotient, a_remainder;

  // wide instance (N=64, M=32, K=4)
  logic        b_in_valid, b_in_ready, b_in_signed, b_out_valid, b_out_ready, b_dbz, b_busy;
  logic [63:0] b_dividend, b_quotient;
  logic [31:0] b_divisor, b_remainder;

  seq_divider #(.N(8), .M(8), .K(1)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_signed(a_in_signed),
    .dividend(a_dividend), .divisor(a_divisor),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .quotient(a_quotient), .remainder(a_remainder),
    .div_by_zero(a_dbz), .busy(a_busy)
  );

  seq_divider #(.N(64), .M(32), .K(4)) u_dut64 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_signed(b_in_signed),
    .dividend(b_dividend), .divisor(b_divisor),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .quotient(b_quotient), .remainder(b_remainder),
    .div_by_zero(b_dbz), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mask(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic longint sext(input logic [63:0] v, input int w);
    return $signed(v << (64 - w)) >>> (64 - w);
  endfunction

  // Reference: plain integer division, truncating toward zero in signed mode.
  task automatic model(input bit sgn, input logic [63:0] a, input logic [63:0] b,
                       input int n, input int m,
                       output logic [63:0] q, output logic [63:0] r, output logic dbz);
    longint sa, sb, sq, sr;
    if (b == 0) begin
      q = mask(n); r = a & mask(m); dbz = 1'b1;
    end else if (!sgn) begin
      q = a / b; r = a % b; dbz = 1'b0;
    end else begin
      sa = sext(a, n);
      sb = sext(b, m);
      if (sb == -1) begin
        sq = -sa; sr = 0;
      end else begin
        sq = sa / sb; sr = sa % sb;
      end
      q = sq & mask(n); r = sr & mask(m); dbz = 1'b0;
    end
  endtask

  function automatic logic get_rdy(input int sel);  return sel != 0 ? b_in_ready  : a_in_ready;  endfunction
  function automatic logic get_ov(input int sel);   return sel != 0 ? b_out_valid : a_out_valid; endfunction
  function automatic logic get_busy(input int sel); return sel != 0 ? b_busy      : a_busy;      endfunction
  function automatic logic get_dbz(input int sel);  return sel != 0 ? b_dbz       : a_dbz;       endfunction
  function automatic logic [63:0] get_q(input int sel);
    return sel != 0 ? b_quotient : {56'd0, a_quotient};
  endfunction
  function automatic logic [63:0] get_r(input int sel);
    return sel != 0 ? {32'd0, b_remainder} : {56'd0, a_remainder};
  endfunction

  task automatic drive(input int sel, input logic v, input logic sgn,
                       input logic [63:0] a, input logic [63:0] b);
    if (sel == 0) begin
      a_in_valid = v; a_in_signed = sgn; a_dividend = a[7:0]; a_divisor = b[7:0];
    end else begin
      b_in_valid = v; b_in_signed = sgn; b_dividend = a; b_divisor = b[31:0];
    end
  endtask

  task automatic set_ready(input int sel, input logic v);
    if (sel == 0) a_out_ready = v; else b_out_ready = v;
  endtask

  // One transaction: accept, measure latency, compare, optionally stall, pop.
  task automatic do_op(input int sel, input bit sgn, input logic [63:0] a_in,
                       input logic [63:0] b_in, input int hold, input string tag);
    logic [63:0] a, b, eq, er;
    logic        ed;
    int          n, m, lat, cyc;
    n = (sel != 0) ? 64 : 8;
    m = (sel != 0) ? 32 : 8;
    a = a_in & mask(n);
    b = b_in & mask(m);
    model(sgn, a, b, n, m, eq, er, ed);
    lat = ed ? 1 : ((sel != 0) ? 17 : 9);

    @(negedge clk);
    cyc = 0;
    while (!get_rdy(sel) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_in_ready"}, 64'(get_rdy(sel)), 64'd1);
    drive(sel, 1'b1, sgn, a, b);
    @(negedge clk);
    drive(sel, 1'b0, ~sgn, {$urandom, $urandom}, {$urandom, $urandom});

    cyc = 0;
    while (!get_ov(sel) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(lat));
    check({tag, "_quotient"}, get_q(sel), eq);
    check({tag, "_remainder"}, get_r(sel), er);
    check({tag, "_dbz"}, 64'(get_dbz(sel)), 64'(ed));

    for (int h = 0; h < hold; h++) begin
      drive(sel, 1'b1, ~sgn, {$urandom, $urandom}, {$urandom, $urandom});
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(get_ov(sel)), 64'd1);
      check({tag, "_hold_in_ready"}, 64'(get_rdy(sel)), 64'd0);
      check({tag, "_hold_quotient"}, get_q(sel), eq);
      check({tag, "_hold_remainder"}, get_r(sel), er);
    end

    drive(sel, 1'b0, 1'b0, 64'd0, 64'd0);
    set_ready(sel, 1'b1);
    @(negedge clk);
    set_ready(sel, 1'b0);
    check({tag, "_pop_valid"}, 64'(get_ov(sel)), 64'd0);
    check({tag, "_pop_in_ready"}, 64'(get_rdy(sel)), 64'd1);
    check({tag, "_pop_busy"}, 64'(get_busy(sel)), 64'd0);
  endtask

  initial begin
    logic [63:0] ra, rb;
    bit          rs;

    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(1, 1'b0, 1'b0, 64'd0, 64'd0);
    a_out_ready = 1'b0;
    b_out_ready = 1'b0;
    #1;
    check("rst_in_ready", 64'(a_in_ready), 64'd1);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_quotient", 64'(a_quotient), 64'd0);
    check("rst_remainder", 64'(a_remainder), 64'd0);
    check("rst_dbz", 64'(a_dbz), 64'd0);
    check("rst_wide_in_ready", 64'(b_in_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // directed 8-bit cases
    do_op(0, 0, 64'd100,  64'd7,    0, "u100_7");
    do_op(0, 0, 64'hFF,   64'h01,   0, "uFF_1");
    do_op(0, 1, 64'hF9,   64'd2,    0, "s_m7_2");
    do_op(0, 1, 64'h07,   64'hFE,   0, "s_7_m2");
    do_op(0, 1, 64'hF9,   64'hFE,   0, "s_m7_m2");
    do_op(0, 1, 64'h80,   64'hFF,   0, "s_ovf");
    do_op(0, 0, 64'h5A,   64'h00,   0, "u_dbz");
    do_op(0, 1, 64'h5A,   64'h00,   0, "s_dbz");
    do_op(0, 0, 64'd100,  64'd7,    0, "dbz_clear");
    do_op(0, 0, 64'd200,  64'd13,   5, "backpressure");
    do_op(0, 1, 64'h9C,   64'h05,   0, "s_m100_5");

    // abort in the middle of CALC
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 64'd100, 64'd7);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_in_ready", 64'(a_in_ready), 64'd1);
    check("abort_busy", 64'(a_busy), 64'd0);
    check("abort_out_valid", 64'(a_out_valid), 64'd0);
    check("abort_quotient", 64'(a_quotient), 64'd0);
    check("abort_remainder", 64'(a_remainder), 64'd0);
    check("abort_dbz", 64'(a_dbz), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("release_in_ready", 64'(a_in_ready), 64'd1);
    do_op(0, 0, 64'd200, 64'd9, 0, "post_rst");

    // wide instance: boundary operands, then random mix
    ra = {$urandom, $urandom};
    do_op(1, 1, ra, 64'd1,           0, "w_s_div1");
    do_op(1, 0, ra, 64'd1,           0, "w_u_div1");
    do_op(1, 1, ra, 64'hFFFF_FFFF,   0, "w_s_divm1");
    do_op(1, 0, ra, 64'hFFFF_FFFF,   0, "w_u_divmax");
    do_op(1, 1, 64'd0, 64'd12345,    0, "w_s_zero_dvd");
    do_op(1, 0, 64'd0, 64'hFFFF_FFFF,0, "w_u_zero_dvd");
    do_op(1, 1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF, 0, "w_s_ovf");
    do_op(1, 1, ra, 64'd0,           0, "w_s_dbz");
    do_op(1, 0, ra, 64'd7,           0, "w_after_dbz");

    for (int i = 0; i < 30; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       rb = 64'($urandom);
        1:       rb = 64'($urandom_range(1, 15));
        2:       rb = -64'($urandom_range(1, 1000));
        default: begin
          rb = 64'($urandom);
          ra = 64'($urandom_range(0, 100000));
        end
      endcase
      do_op(1, rs, ra, rb, (i % 7 == 0) ? 2 : 0, $sformatf("w_rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative multi-bit restoring divider, the parametrised successor to the team's single-bit shift-subtract divider. It adds signed (truncating) and unsigned modes, a configurable number of quotient bits per cycle, divide-by-zero flagging and valid/ready handshakes on both sides. It sits behind the arithmetic dispatch as a non-pipelined, one-operation-at-a-time slave.

## Interface
- N, 64, dividend/quotient width; N % K == 0 required
- M, 64, divisor/remainder width; M <= N required
- K, 1, quotient bits retired per CALC cycle; legal values 1, 2, 4
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  operands and mode present
- in_ready  out  1  block can accept; equals (state == IDLE)
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned
- dividend  in  N  numerator
- divisor  in  M  denominator
- out_valid  out  1  result registers valid
- out_ready  in  1  consumer takes the result
- quotient  out  N  result quotient
- remainder  out  M  result remainder
- div_by_zero  out  1  divisor was 0 for the current result
- busy  out  1  state != IDLE

## Operation
- States: IDLE, CALC, FIX, DONE. Unused encodings go to IDLE.
- IDLE: accept on in_valid & in_ready.
  - Latch the operand sign flags when in_signed is set: dividend[N-1] and divisor[M-1].
  - Latch the operand magnitudes. Negation is two's complement at full width, so -2^(N-1) yields 2^(N-1) unsigned.
  - Clear the partial remainder (M+1 bits) and the iteration counter.
  - divisor == 0: go to DONE directly with quotient = all ones, remainder = dividend[M-1:0], div_by_zero = 1. No sign handling.
  - Otherwise go to CALC.
- CALC: each cycle performs K chained restoring steps:
  - shift in the next dividend MSB;
  - compare against the divisor magnitude;
  - subtract if greater or equal;
  - shift in the quotient bit.
  - After N/K cycles go to FIX.
- FIX:
  - Quotient is negated if in_signed and the sign flags differ.
  - Remainder is negated if in_signed and the dividend was negative. Division truncates toward zero; the remainder takes the dividend's sign.
  - Load the output registers, set out_valid, go to DONE.
- Signed overflow (-2^(N-1) / -1) falls out naturally: quotient = -2^(N-1) bit pattern, remainder = 0, div_by_zero = 0.
- DONE: hold quotient, remainder and div_by_zero stable while out_valid & !out_ready.
  - On out_valid & out_ready: clear out_valid, go to IDLE.
  - Output registers keep their last value until the next FIX or divide-by-zero load.
- in_valid outside IDLE is ignored; operand changes have no effect.

## Timing
- Reset values:
  - state IDLE, in_ready 1, busy 0, out_valid 0;
  - quotient, remainder and div_by_zero all 0;
  - internal registers 0.
- Reset mid-operation aborts immediately. No result is produced; in_ready is 1 in the first cycle after release.
- Acceptance at edge T:
  - normal case: out_valid is high after edge T+N/K+1, i.e. N/K+1 cycles of latency (N=64, K=1 gives 65; K=4 gives 17);
  - divide-by-zero: out_valid is high after edge T+1.
- Output handshake at edge D: out_valid and busy are low and in_ready is high after D. The next acceptance is possible at D+1 at the earliest, so throughput is one op per N/K+3 cycles with out_ready held high.
- in_ready and busy are pure decodes of the registered state; no combinational path from in_valid or out_ready to any output.
- K-step logic is one combinational chain per cycle; the critical path is K subtractors of M+1 bits.

## Test plan
- Unsigned, N=M=8, K=1: 100 / 7 -> quotient 14 (0x0E), remainder 2.
  - out_valid exactly 9 cycles after acceptance.
  - 0xFF / 0x01 -> quotient 0xFF, remainder 0.
- Signed, N=M=8:
  - -7 / 2 -> quotient 0xFD, remainder 0xFF.
  - 7 / -2 -> quotient 0xFD, remainder 1.
  - -7 / -2 -> quotient 3, remainder 0xFF.
  - -128 / -1 -> quotient 0x80, remainder 0, div_by_zero 0.
- Divide-by-zero, both modes: 0x5A / 0 -> quotient 0xFF, remainder 0x5A, div_by_zero 1.
  - out_valid 1 cycle after acceptance.
  - The next normal op clears div_by_zero.
- Backpressure: hold out_ready low 5 cycles after out_valid.
  - Outputs are stable and in_ready stays 0.
  - New operands presented with in_valid are ignored.
  - Result pops on the first out_ready cycle; in_ready rises the next cycle.
- Reset mid-CALC at iteration 3: all outputs return to reset values asynchronously. A following 200 / 9 (unsigned) gives quotient 22, remainder 2.
- Width/radix sweep: N=64, M=32, K=4 with random signed and unsigned operands against a reference model.
  - Latency is 17 cycles in every case.
  - Include divisor 1, divisor 0xFFFFFFFF signed (-1), and dividend 0.
